ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX register and consumes its outputs: PC, both register operands, the sign-extended immediate, the two destination-register candidates, and the WB/MEM/EX control bundles.
- It performs the ALU operation, computes the branch target and selects the destination register.
- It registers the results into the EX/MEM pipeline register.
- An optional iterative multiplier stalls the upstream stages while it runs.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- MUL_CYCLES, 32, number of iteration cycles in the multiplier. Used only with MULT_EN.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Flush  in  1  turn the current EX contents into a bubble (taken branch)
- PC_IN  in  32  PC+4 of the instruction, from ID/EX
- RD1_IN  in  32  rs operand
- RD2_IN  in  32  rt operand
- IR_LO_EX_IN  in  32  sign-extended immediate; bits [5:0] are funct
- WR1_IN  in  5  rt field
- WR2_IN  in  5  rd field
- WB_IN  in  2  WB controls, passed through
- MEM_IN  in  3  MEM controls, passed through
- EX_IN  in  4  bit 3 RegDst, bits [2:1] ALUOp, bit 0 ALUSrc
- Busy  out  1  combinational stall request to the PC, IF/ID and ID/EX registers
- BranchPC_OUT  out  32  registered branch target
- Zero_OUT  out  1  registered ALU-zero flag
- ALUResult_OUT  out  32  registered result
- RD2_OUT  out  32  registered store data
- WriteReg_OUT  out  5  registered destination register
- WB_OUT  out  2  registered WB controls
- MEM_OUT  out  3  registered MEM controls

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low, on Rst_n.
- Reset values: every registered output is 0, the FSM is in IDLE, and Busy is 0.
- Operand B: RD2_IN when ALUSrc=0, IR_LO_EX_IN when ALUSrc=1.
- ALUOp decode:
  - 00: add.
  - 01: subtract.
  - 11: OR.
  - 10: decode funct. 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A signed slt giving 1 or 0.
  - Any other funct gives result 0.
- Arithmetic: all operations are modulo 2^32 and no overflow trap is raised.
- Zero flag: Zero = (result == 0).
- Branch target: BranchPC = PC_IN + (IR_LO_EX_IN << 2), truncated to 32 bits.
- Destination register: WriteReg = WR2_IN when RegDst=1, WR1_IN when RegDst=0.
- Latency: one cycle. Outputs are valid after the edge that ends the instruction's EX cycle.
- Flush=1 at an edge: WB_OUT and MEM_OUT load 0 (bubble). The data outputs are don't-care but are loaded normally. Flush has priority over every other event.
- Busy:
  - Busy is 0 whenever MULT_EN is undefined.
  - Upstream must hold the ID/EX contents stable while Busy=1.
  - The EX/MEM register loads a bubble on every cycle in which Busy=1.

Optional Feature:
- Macro: MULT_EN.
- Defined: R-type funct 0x18 (mul) is a multi-cycle unsigned shift-add multiply that writes the low 32 bits of the product to rd.
- FSM states IDLE, MUL, DONE:
  - IDLE with a mul decoded and no Flush: Busy=1 combinationally. Operands are captured, count=0, next state MUL.
  - MUL: Busy=1. Each cycle, if multiplier bit[0] is 1 the accumulator adds the multiplicand. The multiplicand shifts left and the multiplier shifts right, and count increments. After MUL_CYCLES cycles, go to DONE.
  - DONE: Busy=0. EX/MEM loads ALUResult=product, Zero=(product==0), and the other fields from the held inputs. Next state IDLE.
- Total Busy: MUL_CYCLES+1 cycles, i.e. 33.
- Flush in MUL or DONE: return to IDLE, load a bubble, Busy=0 on the next cycle.
- Rst_n low mid-operation: IDLE immediately and all outputs cleared.
- Undefined: funct 0x18 falls into the "other funct" case, giving result 0 and no stall. The FSM logic is absent.

Test Plan:
- Reset: Rst_n=0 during an add. Required: all outputs 0 immediately and Busy=0. Release, then RD1=5, RD2=7, EX=4'b1100, funct 0x20, WR2=9. Required next cycle: ALUResult=12, WriteReg=9, Zero=0.
- beq: EX=4'b0010, RD1=RD2=0x1234, PC_IN=0x100, IR_LO=0xFFFFFFFE. Required: Zero=1, BranchPC=0xF8.
- lw/slt: ALUSrc=1, RD1=0x1000, imm=0xFFFFFFFC gives ALUResult=0xFFC with WriteReg=WR1. Then slt with RD1=0xFFFFFFFF, RD2=1 gives result 1.
- Flush: WB_IN=2'b11, MEM_IN=3'b010 with Flush=1. Required: WB_OUT=0 and MEM_OUT=0 after the edge.
- MULT_EN: RD1=0x0001_0003, RD2=0x0000_0005, mul. Required: Busy high for exactly 33 cycles with WB_OUT=0 throughout, then ALUResult=0x0005_000F. For 0xFFFFFFFF×2, ALUResult=0xFFFFFFFE.
- MULT_EN: Flush, and separately Rst_n=0, asserted at MUL cycle 10. Required: Busy=0 next cycle, bubble in EX/MEM, and the next add executes normally.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target, destination select and the EX/MEM register.
// Define MULT_EN to add the iterative shift-add multiplier (funct 0x18) with upstream stall.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic [DATA_W-1:0] RD1_IN,
  input  logic [DATA_W-1:0] RD2_IN,
  input  logic [DATA_W-1:0] IR_LO_EX_IN,
  input  logic [4:0]        WR1_IN,
  input  logic [4:0]        WR2_IN,
  input  logic [1:0]        WB_IN,
  input  logic [2:0]        MEM_IN,
  input  logic [3:0]        EX_IN,
  output logic              Busy,
  output logic [DATA_W-1:0] BranchPC_OUT,
  output logic              Zero_OUT,
  output logic [DATA_W-1:0] ALUResult_OUT,
  output logic [DATA_W-1:0] RD2_OUT,
  output logic [4:0]        WriteReg_OUT,
  output logic [1:0]        WB_OUT,
  output logic [2:0]        MEM_OUT
);

  if (DATA_W != 32 || MUL_CYCLES < 1) begin : g_bad_cfg
    $error("ex_stage supports DATA_W=32 and MUL_CYCLES>=1 only");
  end

  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_res_s;
  logic [DATA_W-1:0] branch_s;
  logic [4:0]        wreg_s;
  logic              busy_s;

  logic [DATA_W-1:0] branch_pc_d, branch_pc_q;
  logic              zero_d, zero_q;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [DATA_W-1:0] rd2_d, rd2_q;
  logic [4:0]        write_reg_d, write_reg_q;
  logic [1:0]        wb_d, wb_q;
  logic [2:0]        mem_d, mem_q;

`ifdef MULT_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] acc_d, acc_q;
  logic [DATA_W-1:0] mcand_d, mcand_q;
  logic [DATA_W-1:0] mplier_d, mplier_q;
  logic              is_mul_s;
`endif

  // Operand select, ALU, branch target and destination register
  always_comb begin
    op_b_s    = EX_IN[0] ? IR_LO_EX_IN : RD2_IN;
    branch_s  = PC_IN + {IR_LO_EX_IN[DATA_W-3:0], 2'b00};
    wreg_s    = EX_IN[3] ? WR2_IN : WR1_IN;
    alu_res_s = {DATA_W{1'b0}};
    case (EX_IN[2:1])
      2'b00: alu_res_s = RD1_IN + op_b_s;
      2'b01: alu_res_s = RD1_IN - op_b_s;
      2'b11: alu_res_s = RD1_IN | op_b_s;
      2'b10: begin
        case (IR_LO_EX_IN[5:0])
          6'h20:   alu_res_s = RD1_IN + op_b_s;
          6'h22:   alu_res_s = RD1_IN - op_b_s;
          6'h24:   alu_res_s = RD1_IN & op_b_s;
          6'h25:   alu_res_s = RD1_IN | op_b_s;
          6'h27:   alu_res_s = ~(RD1_IN | op_b_s);
          6'h2A:   alu_res_s = ($signed(RD1_IN) < $signed(op_b_s)) ? DATA_W'(1) : {DATA_W{1'b0}};
          default: alu_res_s = {DATA_W{1'b0}};
        endcase
      end
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  // EX/MEM next values, multiplier sequencing and bubble insertion
  always_comb begin
    branch_pc_d  = branch_s;
    zero_d       = (alu_res_s == {DATA_W{1'b0}});
    alu_result_d = alu_res_s;
    rd2_d        = RD2_IN;
    write_reg_d  = wreg_s;
    wb_d         = WB_IN;
    mem_d        = MEM_IN;
    busy_s       = 1'b0;
`ifdef MULT_EN
    is_mul_s = (EX_IN[2:1] == 2'b10) && (IR_LO_EX_IN[5:0] == 6'h18);
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE: begin
        // Reset is folded in so Busy reads 0 while Rst_n is held low
        if (is_mul_s && !Flush && Rst_n) begin
          busy_s   = 1'b1;
          mcand_d  = RD1_IN;
          mplier_d = op_b_s;
          acc_d    = {DATA_W{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        busy_s   = 1'b1;
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (Flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        alu_result_d = acc_q;
        zero_d       = (acc_q == {DATA_W{1'b0}});
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`endif
    if (busy_s || Flush) begin
      wb_d  = 2'b00;
      mem_d = 3'b000;
    end else begin
      wb_d  = wb_d;
      mem_d = mem_d;
    end
  end

  // EX/MEM pipeline register and multiplier state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      branch_pc_q  <= {DATA_W{1'b0}};
      zero_q       <= 1'b0;
      alu_result_q <= {DATA_W{1'b0}};
      rd2_q        <= {DATA_W{1'b0}};
      write_reg_q  <= 5'd0;
      wb_q         <= 2'b00;
      mem_q        <= 3'b000;
`ifdef MULT_EN
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      acc_q        <= {DATA_W{1'b0}};
      mcand_q      <= {DATA_W{1'b0}};
      mplier_q     <= {DATA_W{1'b0}};
`endif
    end else begin
      branch_pc_q  <= branch_pc_d;
      zero_q       <= zero_d;
      alu_result_q <= alu_result_d;
      rd2_q        <= rd2_d;
      write_reg_q  <= write_reg_d;
      wb_q         <= wb_d;
      mem_q        <= mem_d;
`ifdef MULT_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
`endif
    end
  end

  assign Busy          = busy_s;
  assign BranchPC_OUT  = branch_pc_q;
  assign Zero_OUT      = zero_q;
  assign ALUResult_OUT = alu_result_q;
  assign RD2_OUT       = rd2_q;
  assign WriteReg_OUT  = write_reg_q;
  assign WB_OUT        = wb_q;
  assign MEM_OUT       = mem_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic against a behavioural model.
// Multiplier scenarios are compiled in when MULT_EN is defined.
module tb_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Flush;
  logic [31:0] PC_IN, RD1_IN, RD2_IN, IR_LO_EX_IN;
  logic [4:0]  WR1_IN, WR2_IN;
  logic [1:0]  WB_IN;
  logic [2:0]  MEM_IN;
  logic [3:0]  EX_IN;
  logic        Busy;
  logic [31:0] BranchPC_OUT, ALUResult_OUT, RD2_OUT;
  logic        Zero_OUT;
  logic [4:0]  WriteReg_OUT;
  logic [1:0]  WB_OUT;
  logic [2:0]  MEM_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .PC_IN(PC_IN), .RD1_IN(RD1_IN), .RD2_IN(RD2_IN), .IR_LO_EX_IN(IR_LO_EX_IN),
    .WR1_IN(WR1_IN), .WR2_IN(WR2_IN), .WB_IN(WB_IN), .MEM_IN(MEM_IN), .EX_IN(EX_IN),
    .Busy(Busy), .BranchPC_OUT(BranchPC_OUT), .Zero_OUT(Zero_OUT),
    .ALUResult_OUT(ALUResult_OUT), .RD2_OUT(RD2_OUT), .WriteReg_OUT(WriteReg_OUT),
    .WB_OUT(WB_OUT), .MEM_OUT(MEM_OUT)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural ALU straight from the opcode table
  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic [5:0] f);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a | b;
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] wr1, input logic [4:0] wr2,
                       input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                       input logic fl);
    PC_IN = pc; RD1_IN = rd1; RD2_IN = rd2; IR_LO_EX_IN = imm;
    WR1_IN = wr1; WR2_IN = wr2; WB_IN = wb; MEM_IN = mem; EX_IN = ex; Flush = fl;
  endtask

  // Predict EX/MEM contents from the current inputs, clock once, compare
  task automatic check_cycle(input string tag);
    logic [31:0] b, res, br;
    b   = EX_IN[0] ? IR_LO_EX_IN : RD2_IN;
    res = model_alu(RD1_IN, b, EX_IN[2:1], IR_LO_EX_IN[5:0]);
    br  = PC_IN + IR_LO_EX_IN * 4;
    check_eq({tag, ".busy"}, {31'd0, Busy}, 32'd0);
    @(posedge Clk);
    #1;
    check_eq({tag, ".branch"}, BranchPC_OUT, br);
    check_eq({tag, ".res"}, ALUResult_OUT, res);
    check_eq({tag, ".zero"}, {31'd0, Zero_OUT}, {31'd0, res == 32'd0});
    check_eq({tag, ".rd2"}, RD2_OUT, RD2_IN);
    check_eq({tag, ".wreg"}, {27'd0, WriteReg_OUT}, {27'd0, EX_IN[3] ? WR2_IN : WR1_IN});
    check_eq({tag, ".wb"}, {30'd0, WB_OUT}, Flush ? 32'd0 : {30'd0, WB_IN});
    check_eq({tag, ".mem"}, {29'd0, MEM_OUT}, Flush ? 32'd0 : {29'd0, MEM_IN});
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, ".busy"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, ".branch"}, BranchPC_OUT, 32'd0);
    check_eq({tag, ".res"}, ALUResult_OUT, 32'd0);
    check_eq({tag, ".zero"}, {31'd0, Zero_OUT}, 32'd0);
    check_eq({tag, ".rd2"}, RD2_OUT, 32'd0);
    check_eq({tag, ".wreg"}, {27'd0, WriteReg_OUT}, 32'd0);
    check_eq({tag, ".wb"}, {30'd0, WB_OUT}, 32'd0);
    check_eq({tag, ".mem"}, {29'd0, MEM_OUT}, 32'd0);
  endtask

`ifdef MULT_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic bubble_bad;
    logic [31:0] prod;
    prod = a * b;
    drive(32'h40, a, b, 32'h0000_0018, 5'd3, 5'd7, 2'b11, 3'b001, 4'b1100, 1'b0);
    n = 0;
    bubble_bad = 1'b0;
    while (Busy === 1'b1 && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
      if (WB_OUT !== 2'b00 || MEM_OUT !== 3'b000) bubble_bad = 1'b1;
    end
    check_eq({tag, ".busy_cycles"}, n, 32'd33);
    check_eq({tag, ".bubble"}, {31'd0, bubble_bad}, 32'd0);
    @(posedge Clk);
    #1;
    check_eq({tag, ".res"}, ALUResult_OUT, prod);
    check_eq({tag, ".zero"}, {31'd0, Zero_OUT}, {31'd0, prod == 32'd0});
    check_eq({tag, ".wreg"}, {27'd0, WriteReg_OUT}, 32'd7);
    check_eq({tag, ".wb"}, {30'd0, WB_OUT}, 32'd3);
    drive(32'h44, 32'd10, 32'd20, 32'h0000_0020, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1100, 1'b0);
    check_cycle({tag, ".after"});
  endtask

  task automatic run_mul_abort(input string tag, input logic use_reset);
    drive(32'h40, 32'h0001_0003, 32'd5, 32'h0000_0018, 5'd3, 5'd7, 2'b11, 3'b001, 4'b1100, 1'b0);
    repeat (10) @(posedge Clk);
    #1;
    if (use_reset) begin
      Rst_n = 1'b0;
      #1;
      check_cleared({tag, ".rst"});
      drive(32'h80, 32'd11, 32'd22, 32'h0000_0020, 5'd4, 5'd5, 2'b10, 3'b010, 4'b1100, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
    end else begin
      Flush = 1'b1;
      @(posedge Clk);
      #1;
      drive(32'h80, 32'd11, 32'd22, 32'h0000_0020, 5'd4, 5'd5, 2'b10, 3'b010, 4'b1100, 1'b0);
      check_eq({tag, ".busy"}, {31'd0, Busy}, 32'd0);
      check_eq({tag, ".wb"}, {30'd0, WB_OUT}, 32'd0);
      check_eq({tag, ".mem"}, {29'd0, MEM_OUT}, 32'd0);
    end
    check_cycle({tag, ".add"});
    check_eq({tag, ".add_res"}, ALUResult_OUT, 32'd33);
  endtask
`endif

  initial begin
    logic [5:0] functs [0:6];
    logic [5:0] f;
    logic [31:0] r1, r2, imm;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
    functs[4] = 6'h27; functs[5] = 6'h2A; functs[6] = 6'h00;

    Rst_n = 1'b0;
    drive(32'h10, 32'd5, 32'd7, 32'h0000_0020, 5'd1, 5'd9, 2'b11, 3'b111, 4'b1100, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check_cleared("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    check_cycle("add");
    check_eq("add.res_const", ALUResult_OUT, 32'd12);
    check_eq("add.wreg_const", {27'd0, WriteReg_OUT}, 32'd9);

    // Asynchronous reset mid-cycle clears loaded contents at once
    #2;
    Rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge Clk);
    Rst_n = 1'b1;

    drive(32'h100, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 5'd2, 5'd3, 2'b00, 3'b100, 4'b0010, 1'b0);
    check_cycle("beq");
    check_eq("beq.zero_const", {31'd0, Zero_OUT}, 32'd1);
    check_eq("beq.branch_const", BranchPC_OUT, 32'h0000_00F8);

    drive(32'h200, 32'h1000, 32'h55, 32'hFFFF_FFFC, 5'd6, 5'd12, 2'b11, 3'b010, 4'b0001, 1'b0);
    check_cycle("lw");
    check_eq("lw.res_const", ALUResult_OUT, 32'h0000_0FFC);
    check_eq("lw.wreg_const", {27'd0, WriteReg_OUT}, 32'd6);

    drive(32'h204, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 5'd6, 5'd12, 2'b10, 3'b000, 4'b1100, 1'b0);
    check_cycle("slt");
    check_eq("slt.res_const", ALUResult_OUT, 32'd1);

    drive(32'h208, 32'd3, 32'd4, 32'h0000_0025, 5'd6, 5'd12, 2'b11, 3'b010, 4'b1100, 1'b1);
    check_cycle("flush");
    check_eq("flush.wb_const", {30'd0, WB_OUT}, 32'd0);
    check_eq("flush.mem_const", {29'd0, MEM_OUT}, 32'd0);

`ifndef MULT_EN
    drive(32'h20C, 32'd3, 32'd4, 32'h0000_0018, 5'd6, 5'd12, 2'b10, 3'b000, 4'b1100, 1'b0);
    check_cycle("mul_off");
    check_eq("mul_off.res_const", ALUResult_OUT, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      f = functs[$urandom_range(0, 6)];
      if (f == 6'h00) f = 6'($urandom);
      if (f == 6'h18) f = 6'h20;
      r1  = $urandom;
      r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      imm = {26'($urandom), f};
      drive($urandom, r1, r2, imm, 5'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            4'($urandom), ($urandom_range(0, 7) == 0));
      check_cycle("rand");
    end
    Flush = 1'b0;

`ifdef MULT_EN
    run_mul("mul_a", 32'h0001_0003, 32'h0000_0005);
    check_eq("mul_a.const", 32'h0001_0003 * 32'h0000_0005, 32'h0005_000F);
    run_mul("mul_b", 32'hFFFF_FFFF, 32'd2);
    run_mul("mul_rand", $urandom, $urandom);
    run_mul_abort("mul_flush", 1'b0);
    run_mul_abort("mul_rst", 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
